// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - byte-level I2C master executing START/STOP/READ_BYTE/WRITE_BYTE commands
// Optional slave clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_master_engine #(
    parameter int QUARTER_PERIOD = 67
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] instruction,
    input  logic [7:0] byteToSend,
    output logic [7:0] byteReceived,
    output logic       complete,
    output logic       ackReceived,
    input  logic       sdaIn,
    output logic       sdaOutEn,
`ifdef I2C_CLOCK_STRETCH_EN
    input  logic       sclIn,
`endif
    output logic       scl
);

    localparam int QW = $clog2(QUARTER_PERIOD);
    localparam logic [QW-1:0] QMAX = QW'(QUARTER_PERIOD - 1);

    localparam logic [1:0] INSTR_START = 2'd0;
    localparam logic [1:0] INSTR_STOP  = 2'd1;
    localparam logic [1:0] INSTR_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_DATA_BITS,
        S_ACK_BIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_phase;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_read;
    logic          r_scl;
    logic          r_sda_en;
    logic          r_complete;
    logic          r_ack;
    logic [7:0]    r_rx_byte;

    logic w_hold;
    logic w_qwrap;
    logic w_last_quarter;
    logic w_first_q2;
    logic w_busy;

`ifdef I2C_CLOCK_STRETCH_EN
    // Stretch only once SCL has been released but the pin is still held low by a slave.
    assign w_hold = (r_phase == 2'd1) && r_scl && !sclIn;
`else
    assign w_hold = 1'b0;
`endif

    assign w_qwrap        = (r_qcnt == QMAX) && !w_hold;
    assign w_last_quarter = w_qwrap && (r_phase == 2'd3);
    assign w_first_q2     = (r_phase == 2'd2) && (r_qcnt == '0);
    assign w_busy         = (r_state == S_START) || (r_state == S_STOP) ||
                            (r_state == S_DATA_BITS) || (r_state == S_ACK_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_qcnt     <= '0;
            r_phase    <= 2'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_read     <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_en   <= 1'b0;
            r_complete <= 1'b0;
            r_ack      <= 1'b0;
            r_rx_byte  <= 8'h00;
        end else begin
            if (w_busy) begin
                if (w_hold) begin
                    r_qcnt <= '0;
                end else if (w_qwrap) begin
                    r_qcnt  <= '0;
                    r_phase <= r_phase + 2'd1;
                end else begin
                    r_qcnt <= r_qcnt + QW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_complete <= 1'b0;
                        r_qcnt     <= '0;
                        r_phase    <= 2'd0;
                        r_bit      <= 3'd0;
                        r_shift    <= byteToSend;
                        r_read     <= (instruction == INSTR_READ);
                        if (instruction == INSTR_START) begin
                            r_state <= S_START;
                        end else if (instruction == INSTR_STOP) begin
                            r_state <= S_STOP;
                        end else begin
                            r_state <= S_DATA_BITS;
                        end
                    end
                end

                S_START: begin
                    case (r_phase)
                        2'd0:    r_sda_en <= 1'b0;
                        2'd1:    r_scl    <= 1'b1;
                        2'd2:    r_sda_en <= 1'b1;
                        default: r_scl    <= 1'b0;
                    endcase
                    if (w_last_quarter) begin
                        r_state    <= S_DONE;
                        r_complete <= 1'b1;
                    end
                end

                S_STOP: begin
                    case (r_phase)
                        2'd0: begin
                            r_sda_en <= 1'b1;
                            r_scl    <= 1'b0;
                        end
                        2'd1:    r_scl    <= 1'b1;
                        2'd2:    r_sda_en <= 1'b0;
                        default: ;
                    endcase
                    if (w_last_quarter) begin
                        r_state    <= S_DONE;
                        r_complete <= 1'b1;
                    end
                end

                S_DATA_BITS: begin
                    case (r_phase)
                        2'd0: begin
                            r_scl    <= 1'b0;
                            r_sda_en <= r_read ? 1'b0 : ~r_shift[7];
                        end
                        2'd1, 2'd2: r_scl <= 1'b1;
                        default:    r_scl <= 1'b0;
                    endcase
                    // Reads fill the shared shift register from the LSB; writes drain it from the MSB.
                    if (w_first_q2 && r_read) begin
                        r_shift <= {r_shift[6:0], sdaIn};
                    end
                    if (w_last_quarter) begin
                        if (!r_read) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_ACK_BIT;
                        end
                    end
                end

                S_ACK_BIT: begin
                    case (r_phase)
                        2'd0: begin
                            r_scl    <= 1'b0;
                            r_sda_en <= r_read;
                        end
                        2'd1, 2'd2: r_scl <= 1'b1;
                        default:    r_scl <= 1'b0;
                    endcase
                    if (w_first_q2 && !r_read) begin
                        r_ack <= ~sdaIn;
                    end
                    if (w_last_quarter) begin
                        if (r_read) begin
                            r_rx_byte <= r_shift;
                        end
                        r_state    <= S_DONE;
                        r_complete <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign scl          = r_scl;
    assign sdaOutEn     = r_sda_en;
    assign complete     = r_complete;
    assign ackReceived  = r_ack;
    assign byteReceived = r_rx_byte;

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb/tb_i2c_master_engine.sv - directed self-checking bench for i2c_master_engine (QUARTER_PERIOD=4)
module tb_i2c_master_engine;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] instruction;
    logic [7:0] byteToSend;
    logic [7:0] byteReceived;
    logic       complete;
    logic       ackReceived;
    logic       sdaIn;
    logic       sdaOutEn;
    logic       scl;
    logic       slave_pull;

    int vectors;
    int miscompares;

    int         r_cyc;
    logic [8:0] r_cap;
    int         r_rises;
    bit         r_fell_hi;
    bit         r_rose_hi;
    logic       r_en9;

    // Open-drain bus: low if either master or slave pulls.
    assign sdaIn = !(sdaOutEn || slave_pull);

    i2c_master_engine #(.QUARTER_PERIOD(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .instruction  (instruction),
        .byteToSend   (byteToSend),
        .byteReceived (byteReceived),
        .complete     (complete),
        .ackReceived  (ackReceived),
        .sdaIn        (sdaIn),
        .sdaOutEn     (sdaOutEn),
`ifdef I2C_CLOCK_STRETCH_EN
        .sclIn        (scl),
`endif
        .scl          (scl)
    );

    always #5 clk = ~clk;

    // Issues one command; slave pattern bit 8 goes out on the first SCL pulse, 1 = slave pulls low.
    task automatic run_cmd(input logic [1:0] ins, input logic [7:0] b, input logic [8:0] pat,
                           input bit keep_en, input bit drop_early);
        logic [8:0] bits;
        bit         prev_scl;
        bit         prev_sda;
        bit         done;
        bits        = pat;
        instruction = ins;
        byteToSend  = b;
        enable      = 1'b1;
        slave_pull  = bits[8];
        prev_scl    = scl;
        prev_sda    = sdaIn;
        r_cap = '0; r_rises = 0; r_fell_hi = 0; r_rose_hi = 0; r_en9 = 1'b0; r_cyc = 0; done = 0;
        @(posedge clk);
        @(negedge clk);
        byteToSend = ~b;
        if (drop_early) enable = 1'b0;
        vectors++;
        if (complete !== 1'b0) begin
            miscompares++;
            $display("FAIL complete_fall instr=%0d: got %b expected 0", ins, complete);
        end
        while (!done && r_cyc < 1000) begin
            if (scl && !prev_scl) begin
                r_cap = {r_cap[7:0], sdaIn};
                r_rises++;
                if (r_rises == 9) r_en9 = sdaOutEn;
            end
            if (scl && prev_scl && prev_sda && !sdaIn) r_fell_hi = 1;
            if (scl && prev_scl && !prev_sda && sdaIn) r_rose_hi = 1;
            prev_sda = sdaIn;
            if (!scl && prev_scl) begin
                bits       = {bits[7:0], 1'b0};
                slave_pull = bits[8];
            end
            prev_scl = scl;
            if (complete) done = 1;
            else begin
                @(posedge clk);
                r_cyc++;
                @(negedge clk);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout instr=%0d: no complete after %0d cycles, expected completion", ins, r_cyc);
        end
        slave_pull = 1'b0;
        if (!keep_en) begin
            enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; instruction = 2'd0; byteToSend = 8'h00; slave_pull = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({scl, sdaOutEn, byteReceived, complete, ackReceived} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: scl=%b en=%b rx=%h cmp=%b ack=%b expected 1 0 00 0 0",
                     scl, sdaOutEn, byteReceived, complete, ackReceived);
        end
    endtask

    task automatic test_start();
        run_cmd(2'd0, 8'h00, 9'h000, 0, 0);
        vectors++;
        if (r_cyc !== 16) begin
            miscompares++; $display("FAIL start_latency: got %0d expected 16", r_cyc);
        end
        vectors++;
        if (r_fell_hi !== 1'b1 || scl !== 1'b0 || sdaOutEn !== 1'b1) begin
            miscompares++;
            $display("FAIL start_lines: fell_hi=%b scl=%b en=%b expected 1 0 1", r_fell_hi, scl, sdaOutEn);
        end
    endtask

    task automatic test_write_ack();
        run_cmd(2'd3, 8'h93, 9'h001, 0, 0);
        vectors++;
        if (r_cap !== 9'h126 || r_rises !== 9) begin
            miscompares++; $display("FAIL write_bits: got %h/%0d expected 126/9", r_cap, r_rises);
        end
        vectors++;
        if (ackReceived !== 1'b1 || r_cyc !== 144) begin
            miscompares++; $display("FAIL write_ack: ack=%b cyc=%0d expected 1 144", ackReceived, r_cyc);
        end
        vectors++;
        if (byteReceived !== 8'h00 || scl !== 1'b0 || sdaOutEn !== 1'b0) begin
            miscompares++;
            $display("FAIL write_hold: rx=%h scl=%b en=%b expected 00 0 0", byteReceived, scl, sdaOutEn);
        end
    endtask

    task automatic test_write_nack();
        run_cmd(2'd3, 8'h5C, 9'h000, 0, 1);
        vectors++;
        if (r_cap !== 9'h0B9 || ackReceived !== 1'b0 || r_cyc !== 144) begin
            miscompares++;
            $display("FAIL write_nack: cap=%h ack=%b cyc=%0d expected 0b9 0 144", r_cap, ackReceived, r_cyc);
        end
    endtask

    task automatic test_read_stop();
        run_cmd(2'd2, 8'hFF, 9'h0B4, 0, 0);
        vectors++;
        if (byteReceived !== 8'hA5 || r_cap !== 9'h14A || r_en9 !== 1'b1) begin
            miscompares++;
            $display("FAIL read_byte: rx=%h cap=%h en9=%b expected a5 14a 1", byteReceived, r_cap, r_en9);
        end
        vectors++;
        if (ackReceived !== 1'b0 || r_cyc !== 144 || scl !== 1'b0 || sdaOutEn !== 1'b1) begin
            miscompares++;
            $display("FAIL read_hold: ack=%b cyc=%0d scl=%b en=%b expected 0 144 0 1",
                     ackReceived, r_cyc, scl, sdaOutEn);
        end
        run_cmd(2'd1, 8'h00, 9'h000, 1, 0);
        vectors++;
        if (r_cyc !== 16 || r_rose_hi !== 1'b1 || scl !== 1'b1 || sdaOutEn !== 1'b0) begin
            miscompares++;
            $display("FAIL stop: cyc=%0d rose_hi=%b scl=%b en=%b expected 16 1 1 0",
                     r_cyc, r_rose_hi, scl, sdaOutEn);
        end
    endtask

    task automatic test_back_to_back();
        bit bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (complete !== 1'b1 || scl !== 1'b1 || sdaOutEn !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++; $display("FAIL no_retrigger: got retrigger=1 expected 0");
        end
        enable = 1'b0;
        @(negedge clk);
        run_cmd(2'd1, 8'h00, 9'h000, 0, 0);
        vectors++;
        if (r_cyc !== 16) begin
            miscompares++; $display("FAIL stop_rearm: got %0d expected 16", r_cyc);
        end
    endtask

    task automatic test_reset_mid_write();
        instruction = 2'd3; byteToSend = 8'h00; enable = 1'b1;
        @(posedge clk);
        repeat (66) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (scl !== 1'b0 || sdaOutEn !== 1'b1 || complete !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_write: scl=%b en=%b cmp=%b expected 0 1 0", scl, sdaOutEn, complete);
        end
        reset = 1'b1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (scl !== 1'b1 || sdaOutEn !== 1'b0 || complete !== 1'b0 || byteReceived !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: scl=%b en=%b cmp=%b rx=%h expected 1 0 0 00",
                     scl, sdaOutEn, complete, byteReceived);
        end
        reset = 1'b0;
        @(negedge clk);
        run_cmd(2'd0, 8'h00, 9'h000, 0, 0);
        vectors++;
        if (r_cyc !== 16 || r_fell_hi !== 1'b1 || scl !== 1'b0 || sdaOutEn !== 1'b1) begin
            miscompares++;
            $display("FAIL start_after_reset: cyc=%0d fell_hi=%b scl=%b en=%b expected 16 1 0 1",
                     r_cyc, r_fell_hi, scl, sdaOutEn);
        end
    endtask

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_start();
        test_write_ack();
        test_write_nack();
        test_read_stop();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
